// File: rtl/dds_pkg.sv
// Shared constants and types for the recursive DDS sine oscillator.
package dds_pkg;

  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FRAC    = 29;
  localparam int unsigned ROM_LAT = 1;

  // Full-precision product and post-shift working width of the recurrence.
  localparam int unsigned PROD_W  = 2 * DATA_W;
  localparam int unsigned SUM_W   = 36;

  // Wait counter only has to reach ROM_LAT.
  localparam int unsigned CNT_W   = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

  // 1.0 in Q3.29.
  localparam logic [DATA_W-1:0] Q_ONE = 32'h2000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2
  } osc_state_e;

endpackage

// File: rtl/osc_mac.sv
// Chebyshev recurrence datapath: P1 registers c*y1, P2 forms (p>>>FRAC)-y2 and updates y1/y2.
// OSC_SAT_EN: clamp the P2 result to the sample range and keep a sticky overflow flag.
module osc_mac
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              seed_en,
  input  logic [DATA_W-1:0] c_in,
  input  logic [DATA_W-1:0] s_in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic              sat_flag
);

  logic signed [DATA_W-1:0] c_q, c_d;
  logic signed [DATA_W-1:0] y1_q, y1_d;
  logic signed [DATA_W-1:0] y2_q, y2_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic signed [PROD_W-1:0] p_q, p_d;
  logic                     pv_q, pv_d;
  logic                     ov_q, ov_d;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [SUM_W-1:0]  t_c;
  logic signed [DATA_W-1:0] t32_c;

  assign prod_c = PROD_W'(c_q) * PROD_W'(y1_q);
  assign t_c    = SUM_W'(p_q >>> FRAC) - SUM_W'(y2_q);

`ifdef OSC_SAT_EN
  localparam logic [DATA_W-1:0] SAMPLE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic ovf_c;
  logic sat_q, sat_d;

  // Result fits only if every bit above the sample sign bit matches the sign.
  assign ovf_c = (t_c[SUM_W-1:DATA_W-1] != {(SUM_W-DATA_W+1){t_c[SUM_W-1]}});
  assign t32_c = ovf_c ? (t_c[SUM_W-1] ? SAMPLE_MIN : SAMPLE_MAX) : DATA_W'(t_c);

  always_comb begin
    sat_d = sat_q;
    if (flush) begin
      sat_d = 1'b0;
    end else if (pv_q && ovf_c) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`else
  assign t32_c    = DATA_W'(t_c);
  assign sat_flag = 1'b0;
`endif

  // Flush kills both stages; seeding only happens while the pipeline is empty.
  always_comb begin
    c_d   = c_q;
    y1_d  = y1_q;
    y2_d  = y2_q;
    out_d = out_q;
    p_d   = p_q;
    pv_d  = 1'b0;
    ov_d  = 1'b0;
    if (flush) begin
      pv_d = 1'b0;
    end else if (seed_en) begin
      c_d  = $signed(c_in);
      y1_d = '0;
      y2_d = -$signed(s_in);
    end else begin
      pv_d = in_valid;
      if (in_valid) begin
        p_d = prod_c;
      end
      if (pv_q) begin
        y2_d  = y1_q;
        y1_d  = t32_c;
        out_d = t32_c;
        ov_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      y1_q  <= '0;
      y2_q  <= '0;
      out_q <= '0;
      p_q   <= '0;
      pv_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      c_q   <= c_d;
      y1_q  <= y1_d;
      y2_q  <= y2_d;
      out_q <= out_d;
      p_q   <= p_d;
      pv_q  <= pv_d;
      ov_q  <= ov_d;
    end
  end

  assign sample_out = out_q;
  assign out_valid  = ov_q;

endmodule

// File: rtl/dds_recur_osc.sv
// Recursive sine oscillator: fetches sin x / 2cos x from the table, then emits sin(kx) per sample.
// OSC_SAT_EN: saturating recurrence with sticky sat_flag (otherwise wraps, sat_flag tied low).
module dds_recur_osc
  import dds_pkg::*;
(
  input  logic              Fg_clk,
  input  logic              Resetn,
  input  logic [ADDR_W-1:0] freq_sel,
  input  logic              freq_load,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] sine1x,
  input  logic [DATA_W-1:0] cos2x,
  input  logic              sample_en,
  output logic              ready,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              sat_flag
);

  osc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q, ready_d;
  logic              seed_en_c;
  logic              accept_c;
  logic              mac_valid;

  // A load always wins: it restarts the fetch from any state and drops a coincident sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ready_d   = ready_q;
    seed_en_c = 1'b0;
    accept_c  = 1'b0;
    if (freq_load) begin
      state_d = FETCH;
      addr_d  = freq_sel;
      cnt_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_d = 1'b0;
        end
        FETCH: begin
          if (cnt_q == CNT_W'(ROM_LAT)) begin
            seed_en_c = 1'b1;
            state_d   = RUN;
            ready_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (ready_q && sample_en) begin
            accept_c = 1'b1;
            ready_d  = 1'b0;
          end else if (mac_valid) begin
            ready_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
    end
  end

  osc_mac u_mac (
    .clk        (Fg_clk),
    .rst_n      (Resetn),
    .flush      (freq_load),
    .seed_en    (seed_en_c),
    .c_in       (cos2x),
    .s_in       (sine1x),
    .in_valid   (accept_c),
    .sample_out (sample_out),
    .out_valid  (mac_valid),
    .sat_flag   (sat_flag)
  );

  assign address      = addr_q;
  assign ready        = ready_q;
  assign sample_valid = mac_valid;

endmodule

// File: tb/tb_dds_recur_osc.sv
// Scoreboard bench for dds_recur_osc with a registered one-cycle coefficient table model.
module tb_dds_recur_osc;
  import dds_pkg::*;

  logic              Fg_clk = 1'b0;
  logic              Resetn;
  logic [ADDR_W-1:0] freq_sel;
  logic              freq_load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] sine1x;
  logic [DATA_W-1:0] cos2x;
  logic              sample_en;
  logic              ready;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              sat_flag;

  localparam logic [DATA_W-1:0] S60 = 32'h1BB6_7AE8;
  localparam logic [DATA_W-1:0] NEG_S60 = 32'hE449_8518;
`ifdef OSC_SAT_EN
  localparam logic [DATA_W-1:0] OVF_VAL = 32'h7FFF_FFFF;
  localparam logic              OVF_SAT = 1'b1;
`else
  localparam logic [DATA_W-1:0] OVF_VAL = 32'h8000_0000;
  localparam logic              OVF_SAT = 1'b0;
`endif

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              s;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_vcyc = -1;
  bit   spacing_on = 1'b0;

  dds_recur_osc dut (
    .Fg_clk       (Fg_clk),
    .Resetn       (Resetn),
    .freq_sel     (freq_sel),
    .freq_load    (freq_load),
    .address      (address),
    .sine1x       (sine1x),
    .cos2x        (cos2x),
    .sample_en    (sample_en),
    .ready        (ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sat_flag     (sat_flag)
  );

  always #5 Fg_clk = ~Fg_clk;
  always @(posedge Fg_clk) cyc <= cyc + 1;

  // Coefficient table: 1 = pi/2, 2 = pi/3, 3 = overflowing 2cos x = 2.0.
  always @(posedge Fg_clk) begin
    case (address)
      11'd1:   begin cos2x <= 32'h0000_0000; sine1x <= Q_ONE; end
      11'd2:   begin cos2x <= Q_ONE;         sine1x <= S60;   end
      11'd3:   begin cos2x <= 32'h4000_0000; sine1x <= Q_ONE; end
      default: begin cos2x <= 32'h0000_0000; sine1x <= 32'h0000_0000; end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every sample_valid must match the oldest expected entry.
  always @(negedge Fg_clk) begin
    exp_t e;
    if (Resetn === 1'b1 && sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected sample_valid", 32'(sample_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sample_out", sample_out, e.d);
        check("sat_flag", 32'(sat_flag), 32'(e.s));
      end
      if (spacing_on && last_vcyc >= 0) check("valid spacing", 32'(cyc - last_vcyc), 32'd3);
      last_vcyc = cyc;
    end
  end

  task automatic step();
    @(posedge Fg_clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic s);
    exp_t e;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a);
    freq_sel  = a;
    freq_load = 1'b1;
    step();
    freq_load = 1'b0;
    sample_en = 1'b0;
    check("address after load", 32'(address), 32'(a));
    check("ready at load", 32'(ready), 32'd0);
    for (int i = 0; i < int'(ROM_LAT); i++) begin
      step();
      check("ready during fetch", 32'(ready), 32'd0);
    end
    step();
    check("ready after fetch", 32'(ready), 32'd1);
  endtask

  task automatic sample(input logic [DATA_W-1:0] d, input logic s);
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (ready !== 1'b1) check("ready wait timeout", 32'(ready), 32'd1);
    push(d, s);
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("pending samples", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Resetn    = 1'b0;
    freq_sel  = '0;
    freq_load = 1'b0;
    sample_en = 1'b0;
    #12;
    check("reset address", 32'(address), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    check("reset sample_out", sample_out, 32'd0);
    check("reset sample_valid", 32'(sample_valid), 32'd0);
    check("reset sat_flag", 32'(sat_flag), 32'd0);
    @(negedge Fg_clk);
    Resetn = 1'b1;
    step();

    // Requests in IDLE are ignored.
    sample_en = 1'b1;
    repeat (4) step();
    check("ready in idle", 32'(ready), 32'd0);
    sample_en = 1'b0;

    // x = pi/2
    do_load(11'd1);
    sample(Q_ONE, 1'b0);
    sample(32'h0000_0000, 1'b0);
    sample(32'hE000_0000, 1'b0);
    sample(32'h0000_0000, 1'b0);
    sample(Q_ONE, 1'b0);
    drain();

    // x = pi/3
    do_load(11'd2);
    sample(S60, 1'b0);
    sample(S60, 1'b0);
    sample(32'h0000_0000, 1'b0);
    sample(NEG_S60, 1'b0);
    sample(NEG_S60, 1'b0);
    sample(32'h0000_0000, 1'b0);
    drain();

    // Overflow on the fourth step.
    do_load(11'd3);
    sample(Q_ONE, 1'b0);
    sample(32'h4000_0000, 1'b0);
    sample(32'h6000_0000, 1'b0);
    sample(OVF_VAL, OVF_SAT);
    drain();
    check("sat_flag held", 32'(sat_flag), 32'(OVF_SAT));

    // Load clears the sticky flag; back-to-back requests with sample_en held high.
    do_load(11'd1);
    check("sat_flag after load", 32'(sat_flag), 32'd0);
    spacing_on = 1'b1;
    last_vcyc  = -1;
    push(Q_ONE, 1'b0);
    push(32'h0000_0000, 1'b0);
    push(32'hE000_0000, 1'b0);
    push(32'h0000_0000, 1'b0);
    push(Q_ONE, 1'b0);
    sample_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      check("ready pattern", 32'(ready), 32'(k % 3 == 0));
    end
    sample_en = 1'b0;
    drain();
    spacing_on = 1'b0;

    // Load coincident with a request: the request is dropped.
    sample_en = 1'b1;
    do_load(11'd2);
    sample(S60, 1'b0);
    drain();

    // Restart one cycle after acceptance: in-flight sample is aborted.
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    check("ready after accept", 32'(ready), 32'd0);
    do_load(11'd1);
    check("sample_out held", sample_out, S60);
    sample(Q_ONE, 1'b0);
    drain();

    // Asynchronous reset mid-RUN.
    #2;
    Resetn = 1'b0;
    #1;
    check("async reset address", 32'(address), 32'd0);
    check("async reset ready", 32'(ready), 32'd0);
    check("async reset sample_out", sample_out, 32'd0);
    check("async reset sample_valid", 32'(sample_valid), 32'd0);
    check("async reset sat_flag", 32'(sat_flag), 32'd0);
    @(negedge Fg_clk);
    Resetn    = 1'b1;
    sample_en = 1'b1;
    repeat (4) step();
    check("ready after reset", 32'(ready), 32'd0);
    sample_en = 1'b0;
    do_load(11'd2);
    sample(S60, 1'b0);
    sample(S60, 1'b0);
    drain();

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dds_recur_osc.md
# dds_recur_osc

Recursive sine oscillator for the DDS function generator, directly downstream of the coefficient table stage. It drives the table's 11-bit `address`, then captures the returned `sine1x` (sin x) and `cos2x` (2·cos x) words, both signed Q3.29. On each accepted sample tick it runs the Chebyshev recurrence y[n] = 2cos(x)·y[n-1] − y[n-2], producing sin(kx) for k = 1, 2, 3, … as a signed Q3.29 stream for the output DAC path.

## Interface
- `ADDR_W`, 11, coefficient table address width
- `DATA_W`, 32, sample and coefficient width
- `FRAC`, 29, fractional bits of Q3.29
- `ROM_LAT`, 1, table read latency in clocks, address register to valid data
---
- `Fg_clk`  in  1  system clock, all logic on rising edge
- `Resetn`  in  1  reset, asynchronous, active-low
- `freq_sel`  in  ADDR_W  frequency index; sampled only when `freq_load`=1
- `freq_load`  in  1  one-cycle pulse; (re)starts the oscillator at `freq_sel`
- `address`  out  ADDR_W  registered address to the coefficient table
- `sine1x`  in  DATA_W  sin x from the table, Q3.29 signed
- `cos2x`  in  DATA_W  2cos x from the table, Q3.29 signed
- `sample_en`  in  1  sample request; accepted only when `ready`=1
- `ready`  out  1  oscillator can accept `sample_en` this cycle
- `sample_out`  out  DATA_W  latest sample, Q3.29 signed; held between updates
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates
- `sat_flag`  out  1  sticky overflow indicator; cleared by `freq_load` (only with `OSC_SAT_EN`)

## Operation
- Reset values: `address`=0, `ready`=0, `sample_out`=0, `sample_valid`=0, `sat_flag`=0, state IDLE, y1=y2=0.
- States and transitions:
  - IDLE -> FETCH on `freq_load`; the load latches `address`←`freq_sel`.
  - FETCH waits ROM_LAT+1 cycles, then captures c←`cos2x` and s←`sine1x`, seeds y1←0 and y2←−s, and goes to RUN.
  - RUN: `ready`=1 when the pipeline is empty.
- Accepted `sample_en` (RUN and `ready`=1) runs a two-stage pipeline:
  - P1: registers the full 64-bit signed product p = c·y1.
  - P2: computes t = (p >>> FRAC) − y2 at 36-bit signed width. Arithmetic shift, truncation toward −∞.
  - P2 then updates y2←y1 and y1←t32, drives `sample_out`←t32 and pulses `sample_valid`.
  - t32 is t reduced to DATA_W; see Configuration.
- `ready` drops in the cycle after acceptance and returns in the cycle after `sample_valid`. Maximum rate is one sample per 3 clocks.
- `sample_en` while `ready`=0 or outside RUN is ignored and not queued.
- The seed makes the output sequence sin x, sin 2x, sin 3x, …
- `freq_load` in any state, including mid-pipeline:
  - aborts any in-flight sample, so no `sample_valid` is produced for it;
  - forces `ready`=0, reloads `address`, and re-enters FETCH;
  - `sample_out` holds its last value.
- `freq_load` coincident with `sample_en`: the load wins and the sample is dropped.
- `Resetn` low mid-operation: all registers return to reset values asynchronously.

## Timing
- `freq_load` at edge E0: `address` is valid after E0.
- Coefficients are captured at edge E0+ROM_LAT+1; `ready`=1 from E0+ROM_LAT+2.
- Sample latency: `sample_en` accepted at edge A gives `sample_valid`=1 and new `sample_out` in the cycle after edge A+1.

## Configuration
- `OSC_SAT_EN` defined: t is clamped to [−2^31, 2^31−1]. Any clamp sets `sat_flag`, which stays set until the next `freq_load`.
- `OSC_SAT_EN` undefined: t32 = t[31:0] (two's-complement wrap) and `sat_flag` is tied to 0.

## Structure
- Shared package `dds_pkg`:
  - constants `ADDR_W`, `DATA_W`, `FRAC`, `ROM_LAT`;
  - a state enum (IDLE, FETCH, RUN);
  - the Q3.29 one constant 32'h2000_0000.
- One sub-module, `osc_mac`: the P1/P2 multiply-shift-subtract-saturate pipeline, with valid in/out and a flush input driven by `freq_load`.
- The state machine and address register live in the top module.

## Test plan
- Reset: `Resetn` low mid-RUN -> all outputs 0 immediately; `ready`=0 until a new `freq_load`.
- x=π/2 (`cos2x`=0, `sine1x`=32'h2000_0000), `freq_load` then 5 samples -> `sample_out` 2000_0000, 0, E000_0000, 0, 2000_0000.
- x=π/3 (`cos2x`=32'h2000_0000, `sine1x`=32'h1BB6_7AE8), 6 samples -> s, s, 0, −s, −s, 0; check bit-exact against a model.
- Overflow (`cos2x`=32'h4000_0000, `sine1x`=32'h2000_0000), 4 samples -> 2000_0000, 4000_0000, 6000_0000, then:
  - with `OSC_SAT_EN`: 7FFF_FFFF and `sat_flag`=1;
  - without it: 8000_0000 and `sat_flag`=0.
- Handshake: `sample_en` held high continuously in RUN -> exactly one `sample_valid` every 3 clocks; `ready` low in the 2 cycles after each acceptance.
- Restart: `freq_load` one cycle after an accepted `sample_en` -> no `sample_valid` for that sample; `address` updated; `ready` back after ROM_LAT+2 edges; next output is the new sin x.
